// File: rtl/shift_div8.sv
// 8-bit unsigned restoring divider, one quotient bit per clock.
// Define SHIFT_DIV8_DBZ_EN to short-circuit and flag divide-by-zero.
module shift_div8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] q,
  output logic [7:0] r,
  output logic       busy,
  output logic       done,
  output logic       dbz
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] quo_q, quo_d;
  logic [7:0] div_q, div_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] q_q, q_d;
  logic [7:0] r_q, r_d;
  logic       dbz_q, dbz_d;

  logic [8:0] t;
  logic [8:0] dif;
  logic       fits;
  logic [7:0] rem_nx;
  logic [7:0] quo_nx;
  logic       zero_b;

  always_comb begin
    t      = {rem_q, quo_q[7]};
    dif    = t - {1'b0, div_q};
    fits   = ~dif[8];
    rem_nx = fits ? dif[7:0] : t[7:0];
    quo_nx = {quo_q[6:0], fits};
  end

`ifdef SHIFT_DIV8_DBZ_EN
  assign zero_b = (b == 8'd0);
`else
  assign zero_b = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          quo_d   = a;
          div_d   = b;
          rem_d   = 8'd0;
          cnt_d   = 3'd7;
          dbz_d   = 1'b0;
          state_d = S_RUN;
          // zero divisor bypasses the iterations entirely
          if (zero_b) begin
            q_d     = 8'hFF;
            r_d     = a;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          q_d     = quo_nx;
          r_d     = rem_nx;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= 8'd0;
      quo_q   <= 8'd0;
      div_q   <= 8'd0;
      cnt_q   <= 3'd0;
      q_q     <= 8'd0;
      r_q     <= 8'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_div8.sv
// Scoreboard bench for shift_div8: stimulus pushes expected
// results, a negedge monitor pops and checks on every done pulse.
module tb_shift_div8;

`ifdef SHIFT_DIV8_DBZ_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] q;
  logic [7:0] r;
  logic       busy;
  logic       done;
  logic       dbz;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   tests;
  int   fails;

  shift_div8 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .dbz  (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [7:0] ia, input logic [7:0] ib, input int n);
    exp_t e;
    if (ib == 8'd0) begin
      e.q   = 8'hFF;
      e.r   = ia;
      e.dbz = DBZ_EN;
      e.cyc = n + (DBZ_EN ? 1 : 8);
    end else begin
      e.q   = ia / ib;
      e.r   = ia % ib;
      e.dbz = 1'b0;
      e.cyc = n + 8;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (q !== e.q || r !== e.r || dbz !== e.dbz) begin
          fails++;
          $display("FAIL result: got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
                   q, r, dbz, e.q, e.r, e.dbz);
        end
        tests++;
        if (cyc != e.cyc) begin
          fails++;
          $display("FAIL done_timing: got cycle %0d expected %0d", cyc, e.cyc);
        end
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL busy_in_done: got %0b expected 0", busy);
        end
      end
    end
  end

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input bit push);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) sb.push_back(mk(ia, ib, cyc));
    chk("busy_after_start", int'(busy), (DBZ_EN && ib == 8'd0) ? 0 : 1);
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    tests = 0;
    fails = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(dbz), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(8'd200, 8'd7, 1'b1);
    repeat (7) begin
      @(posedge clk);
      #1;
      chk("busy_run", int'(busy), 1);
    end
    drain(20);
    chk("hold_q", int'(q), 28);
    chk("hold_r", int'(r), 4);

    issue(8'd255, 8'd1, 1'b1);
    drain(20);
    issue(8'd5, 8'd9, 1'b1);
    drain(20);
    issue(8'd0, 8'd3, 1'b1);
    drain(20);
    issue(8'h5A, 8'd0, 1'b1);
    drain(20);

    issue(8'd100, 8'd10, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 8'd99;
    b     = 8'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain(20);
    repeat (12) @(posedge clk);
    #1;

    issue(8'd150, 8'd4, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_q", int'(q), 0);
    chk("mid_rst_r", int'(r), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_dbz", int'(dbz), 0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    issue(8'd17, 8'd5, 1'b1);
    drain(20);

    start = 1'b1;
    a     = 8'd77;
    b     = 8'd6;
    @(posedge clk);
    #1;
    sb.push_back(mk(8'd77, 8'd6, cyc));
    sb.push_back(mk(8'd201, 8'd13, cyc + 9));
    a = 8'd201;
    b = 8'd13;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    drain(30);

    for (int i = 0; i < 150; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      issue(ra, rb, 1'b1);
      drain(20);
      chk("inv_a", int'(q) * int'(rb) + int'(r), int'(ra));
      chk("inv_r_lt_b", int'(r < rb), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
